// File: rtl/dac_ad9122_pkg.sv
// Shared constants, response codes and FSM encodings for the
// AD9122 DAC AXI4-Lite register slave.
package dac_ad9122_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [2:0] IDX_REG0 = 3'd0;
  localparam logic [2:0] IDX_REG1 = 3'd1;
  localparam logic [2:0] IDX_REG2 = 3'd2;
  localparam logic [2:0] IDX_REG3 = 3'd3;
  localparam logic [2:0] IDX_ID   = 3'd4;

  localparam logic [4:0] OFS_REG0 = 5'h00;
  localparam logic [4:0] OFS_REG1 = 5'h04;
  localparam logic [4:0] OFS_REG2 = 5'h08;
  localparam logic [4:0] OFS_REG3 = 5'h0C;
  localparam logic [4:0] OFS_ID   = 5'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RDATA
  } rd_state_t;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] cur,
    input logic [31:0] nxt,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = cur;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = nxt[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dac_ad9122_s00_axi_regs_if.sv
// AXI4-Lite bus bundle between a master and the DAC register slave.
interface dac_ad9122_s00_axi_regs_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arprot, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );
endinterface

// File: rtl/dac_ad9122_s00_axi_regs.sv
// AXI4-Lite slave: four RW control words and an ID word for the
// AD9122 DAC datapath, with independent AW/W capture.
module dac_ad9122_s00_axi_regs
  import dac_ad9122_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_ID_VALUE = 32'hAD91_2200
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_areset,
  dac_ad9122_s00_axi_regs_if.slave s00_axi,
  output logic [31:0] reg0_o,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic [31:0] reg3_o,
  output logic [3:0]  reg_wr_stb_o
);

  wr_state_t   ws, ws_n;
  rd_state_t   rs, rs_n;
  logic        rdy_en;

  logic [31:0] regs [NUM_REGS];
  logic [2:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [3:0]  stb_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        commit;
  logic [2:0]  c_idx;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic [2:0]  ar_idx;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

  wire unused = &{1'b0, s00_axi.awprot, s00_axi.arprot,
                  s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  // rdy_en keeps every ready low until the first edge after reset
  assign s00_axi.awready = rdy_en &
    ((ws == WR_IDLE) | (ws == WR_HAVE_W));
  assign s00_axi.wready = rdy_en &
    ((ws == WR_IDLE) | (ws == WR_HAVE_AW));
  assign s00_axi.arready = rdy_en & (rs == RD_IDLE);

  assign s00_axi.bvalid = (ws == WR_RESP);
  assign s00_axi.bresp  = bresp_q;
  assign s00_axi.rvalid = (rs == RD_RDATA);
  assign s00_axi.rdata  = rdata_q;
  assign s00_axi.rresp  = rresp_q;

  assign reg0_o       = regs[0];
  assign reg1_o       = regs[1];
  assign reg2_o       = regs[2];
  assign reg3_o       = regs[3];
  assign reg_wr_stb_o = stb_q;

  assign aw_hs  = s00_axi.awvalid & s00_axi.awready;
  assign w_hs   = s00_axi.wvalid & s00_axi.wready;
  assign ar_hs  = s00_axi.arvalid & s00_axi.arready;
  assign ar_idx = s00_axi.araddr[4:2];

  // the second channel to arrive commits straight from the bus
  assign c_idx  = (ws == WR_HAVE_AW) ? aw_idx_q
                                     : s00_axi.awaddr[4:2];
  assign c_data = (ws == WR_HAVE_W) ? wdata_q : s00_axi.wdata;
  assign c_strb = (ws == WR_HAVE_W) ? wstrb_q : s00_axi.wstrb;

  always_comb begin
    ws_n   = ws;
    commit = 1'b0;
    unique case (ws)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          ws_n   = WR_RESP;
          commit = 1'b1;
        end else if (aw_hs) begin
          ws_n = WR_HAVE_AW;
        end else if (w_hs) begin
          ws_n = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        if (w_hs) begin
          ws_n   = WR_RESP;
          commit = 1'b1;
        end
      end
      WR_HAVE_W: begin
        if (aw_hs) begin
          ws_n   = WR_RESP;
          commit = 1'b1;
        end
      end
      WR_RESP: begin
        if (s00_axi.bready) ws_n = WR_IDLE;
      end
      default: ws_n = WR_IDLE;
    endcase
  end

  always_comb begin
    rs_n = rs;
    unique case (rs)
      RD_IDLE:  if (ar_hs) rs_n = RD_RDATA;
      RD_RDATA: if (s00_axi.rready) rs_n = RD_IDLE;
      default:  rs_n = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    unique case (1'b1)
      !ar_idx[2]:         rd_word = regs[ar_idx[1:0]];
      (ar_idx == IDX_ID): rd_word = C_ID_VALUE;
      default:            rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ws       <= WR_IDLE;
      rs       <= RD_IDLE;
      rdy_en   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      stb_q    <= '0;
      regs     <= '{default: '0};
    end else begin
      ws     <= ws_n;
      rs     <= rs_n;
      rdy_en <= 1'b1;
      stb_q  <= '0;
      if (aw_hs) aw_idx_q <= s00_axi.awaddr[4:2];
      if (w_hs) begin
        wdata_q <= s00_axi.wdata;
        wstrb_q <= s00_axi.wstrb;
      end
      if (commit) begin
        unique case (1'b1)
          !c_idx[2]: begin
            regs[c_idx[1:0]] <=
              byte_merge(regs[c_idx[1:0]], c_data, c_strb);
            stb_q[c_idx[1:0]] <= |c_strb;
            bresp_q <= RESP_OKAY;
          end
          (c_idx == IDX_ID): bresp_q <= RESP_OKAY;
          default:           bresp_q <= RESP_SLVERR;
        endcase
      end
      // reads sample regs before this edge's commit lands
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_dac_ad9122_s00_axi_regs.sv
// Randomized self-checking bench for the DAC AXI4-Lite register slave
// against a word-array reference model.
module tb_dac_ad9122_s00_axi_regs;

  localparam logic [31:0] ID = 32'hAD91_2200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_ad9122_s00_axi_regs_if #(.AW(5), .DW(32)) bus ();

  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  stb;

  dac_ad9122_s00_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .C_ID_VALUE(ID)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_areset(rst),
    .s00_axi(bus),
    .reg0_o(reg0),
    .reg1_o(reg1),
    .reg2_o(reg2),
    .reg3_o(reg3),
    .reg_wr_stb_o(stb)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [4];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_reg(input int i);
    case (i)
      0: return reg0;
      1: return reg1;
      2: return reg2;
      default: return reg3;
    endcase
  endfunction

  function automatic logic [31:0] apply(input logic [31:0] old,
    input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask;
    mask = 0;
    for (int k = 0; k < 4; k++)
      if (strb[k]) mask = mask | (32'hFF << (8 * k));
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic logic rdy(input int which);
    case (which)
      0: return bus.awready;
      1: return bus.wready;
      default: return bus.arready;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) check(tag, out_reg(i), model[i]);
  endtask

  task automatic wait_rdy(input string tag, input int which);
    int n;
    n = 0;
    while (!rdy(which) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send_aw(input logic [4:0] addr);
    @(negedge clk);
    bus.awaddr = addr;
    bus.awvalid = 1'b1;
    wait_rdy("aw", 0);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    bus.wdata = data;
    bus.wstrb = strb;
    bus.wvalid = 1'b1;
    wait_rdy("w", 1);
    @(posedge clk);
    @(negedge clk);
    bus.wvalid = 1'b0;
  endtask

  task automatic send_both(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    @(negedge clk);
    bus.awaddr = addr;
    bus.wdata = data;
    bus.wstrb = strb;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    wait_rdy("aw", 0);
    check("wready_with_aw", bus.wready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
  endtask

  // order: 0 together, 1 AW first, 2 W first; gap idle cycles between
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
    input logic [3:0] strb, input int order, input int gap, input int hold);
    int idx;
    logic [1:0] er;
    logic [3:0] es;
    idx = int'(addr) / 4;
    er = (idx <= 4) ? 2'b00 : 2'b10;
    es = (idx < 4 && strb != 0) ? (4'b1 << idx) : 4'b0;
    if (order == 0) begin
      send_both(addr, data, strb);
    end else begin
      if (order == 1) send_aw(addr);
      else send_w(data, strb);
      repeat (gap) begin
        @(negedge clk);
        check("bvalid_early", bus.bvalid, 1'b0);
        check_regs("reg_early");
      end
      if (order == 1) send_w(data, strb);
      else send_aw(addr);
    end
    if (idx < 4) model[idx] = apply(model[idx], data, strb);
    check("bvalid", bus.bvalid, 1'b1);
    check("bresp", bus.bresp, er);
    check("wr_stb", stb, es);
    check_regs("reg_out");
    repeat (hold) begin
      @(negedge clk);
      check("bvalid_hold", bus.bvalid, 1'b1);
      check("bresp_hold", bus.bresp, er);
      check("awready_hold", bus.awready, 1'b0);
      check("wready_hold", bus.wready, 1'b0);
    end
    bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    check("bvalid_clear", bus.bvalid, 1'b0);
    check("wr_stb_clear", stb, 4'b0);
  endtask

  task automatic do_read(input logic [4:0] addr, input int hold);
    int idx;
    logic [31:0] ed;
    logic [1:0] er;
    idx = int'(addr) / 4;
    ed = (idx < 4) ? model[idx] : (idx == 4) ? ID : 32'd0;
    er = (idx <= 4) ? 2'b00 : 2'b10;
    @(negedge clk);
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    wait_rdy("ar", 2);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rvalid", bus.rvalid, 1'b1);
    check("rdata", bus.rdata, ed);
    check("rresp", bus.rresp, er);
    repeat (hold) begin
      @(negedge clk);
      check("rvalid_hold", bus.rvalid, 1'b1);
      check("rdata_hold", bus.rdata, ed);
      check("arready_hold", bus.arready, 1'b0);
    end
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
    check("rvalid_clear", bus.rvalid, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, bus.awready, 1'b0);
    check({tag, "_wready"}, bus.wready, 1'b0);
    check({tag, "_arready"}, bus.arready, 1'b0);
    check({tag, "_bvalid"}, bus.bvalid, 1'b0);
    check({tag, "_rvalid"}, bus.rvalid, 1'b0);
    check({tag, "_bresp"}, bus.bresp, 2'b00);
    check({tag, "_rresp"}, bus.rresp, 2'b00);
    check({tag, "_rdata"}, bus.rdata, 32'd0);
    check({tag, "_stb"}, stb, 4'b0);
    check_regs({tag, "_reg"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, old;
    int cnt;
    bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0;
    bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
    bus.bready = 0;
    bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0;
    bus.rready = 0;
    for (int i = 0; i < 4; i++) model[i] = 0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("ready_before_edge", bus.awready, 1'b0);
    @(negedge clk);
    check("awready_after_rst", bus.awready, 1'b1);
    check("arready_after_rst", bus.arready, 1'b1);

    for (int i = 0; i < 4; i++)
      do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(5'(4 * i), 0);

    do_write(5'h04, 32'hDEADBEEF, 4'hF, 2, 3, 0);
    check("reg1_deadbeef", reg1, 32'hDEADBEEF);

    do_write(5'h08, 32'h11223344, 4'hF, 1, 1, 0);
    do_write(5'h08, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    check("reg2_merge", reg2, 32'h11BB33DD);
    do_write(5'h00, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);

    do_write(5'h14, 32'h12345678, 4'hF, 0, 0, 0);
    do_write(5'h10, 32'h12345678, 4'hF, 2, 1, 0);
    do_read(5'h1C, 0);
    do_read(5'h10, 0);

    do_write(5'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 10);
    do_read(5'h0C, 10);

    // simultaneous read and write to one register
    d = $urandom;
    old = model[3];
    @(negedge clk);
    bus.awaddr = 5'h0C; bus.wdata = d; bus.wstrb = 4'hF;
    bus.araddr = 5'h0C;
    bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    model[3] = d;
    check("rdw_rdata_old", bus.rdata, old);
    check("rdw_reg3_new", reg3, d);
    check("rdw_bvalid", bus.bvalid, 1'b1);
    bus.bready = 1; bus.rready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 0; bus.rready = 0;

    // back-to-back reads with rready held high
    bus.araddr = 5'h10; bus.arvalid = 1; bus.rready = 1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rvalid) cnt++;
    end
    bus.arvalid = 0;
    @(negedge clk);
    bus.rready = 0;
    check("b2b_beats", 32'(cnt), 32'd5);

    for (int n = 0; n < 60; n++) begin
      logic [4:0] a;
      a = 5'({$urandom_range(0, 7)} * 4);
      if ($urandom_range(0, 2) < 2)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end

    // reset with AW latched and W outstanding
    send_aw(5'h00);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) model[i] = 0;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready_low", bus.wready, 1'b0);
    d = $urandom;
    send_w(d, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_bvalid", bus.bvalid, 1'b0);
      check_regs("midrst_no_write");
    end
    send_aw(5'h08);
    model[2] = d;
    check("midrst_bvalid", bus.bvalid, 1'b1);
    check_regs("midrst_reg");
    bus.bready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_ad9122_s00_axi_regs.md
DAC_AD9122_S00_AXI_REGS -- requirements
Module: dac_ad9122_s00_axi_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte-address width.
REQ-003 SHALL have parameter C_ID_VALUE, default 32'hAD91_2200, read-only ID word.
REQ-004 s00_axi_aclk  in  1  single clock for all logic.
REQ-005 s00_axi_areset  in  1  asynchronous, active-high reset.
REQ-006 s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  5/3/1/1  write address channel; awprot ignored.
REQ-007 s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-008 s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-009 s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  5/3/1/1  read address channel; arprot ignored.
REQ-010 s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-011 reg0_o..reg3_o  out  32 each  current contents of RW registers 0x00/0x04/0x08/0x0C to DAC datapath.
REQ-012 reg_wr_stb_o  out  4  one-cycle pulse, bit n set in the cycle after register n is written.

Function
REQ-013 Address decode SHALL use awaddr/araddr[4:2]; 0..3 = RW registers, 4 (0x10) = ID read-only, 5..7 = unmapped.
REQ-014 AW and W SHALL be accepted independently; each channel's ready is high while its holding latch is empty and bvalid is low.
REQ-015 When both latches are full, the write SHALL commit on the next clock edge; bvalid rises in the same edge; both latches clear.
REQ-016 Write commit SHALL update only bytes with wstrb[k]=1; wstrb=0 leaves register unchanged but still responds OKAY.
REQ-017 Write to 0x10 SHALL be ignored with bresp=OKAY; write to 5..7 SHALL be ignored with bresp=SLVERR (2'b10).
REQ-018 bvalid SHALL hold with bresp stable until bready=1; no new AW/W accepted while bvalid=1.
REQ-019 arready SHALL be high while rvalid is low; an accepted read SHALL present rvalid, rdata, rresp in the next cycle (latency 1).
REQ-020 rdata/rresp SHALL hold stable until rready=1; unmapped read returns rdata=0, rresp=SLVERR.
REQ-021 Read and write commit to the same register in the same cycle: read SHALL return the pre-write value.
REQ-022 Back-to-back reads SHALL sustain one transfer every 2 cycles with rready held high.
REQ-023 Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP; read FSM states: IDLE, RDATA; no other states.
REQ-024 reg_wr_stb_o bit SHALL pulse only for committed writes to 0..3 with any wstrb bit set.

Reset
REQ-025 Assertion of s00_axi_areset SHALL immediately force: all readys 0, bvalid 0, rvalid 0, bresp/rresp 0, rdata 0, reg0_o..reg3_o 0, reg_wr_stb_o 0, both FSMs IDLE.
REQ-026 Reset mid-transaction SHALL discard latched AW/W and any pending response; no register update.
REQ-027 awready/wready/arready SHALL rise no earlier than the first clock edge after reset deassertion.

Structure
REQ-028 Register offsets, index constants, response codes (OKAY/SLVERR) and FSM state enums SHALL live in shared package dac_ad9122_pkg.
REQ-029 No sub-module; both channel FSMs and the register array SHALL be in this module.

Verification
REQ-030 Write 0x1,0x2,0x3,0x4 to 0x00..0x0C, read back -> rdata 0x1..0x4, all resp OKAY, reg0_o..reg3_o match, each strobe bit pulses once.
REQ-031 W presented 3 cycles before AW to 0x04, data 0xDEADBEEF -> no commit until AW; bvalid exactly one cycle after AW handshake; reg1_o=0xDEADBEEF.
REQ-032 reg2=0x11223344, write 0xAABBCCDD strobe 4'b0101 -> reg2_o=0x11BB33DD.
REQ-033 Write 0x14 and read 0x1C -> bresp=SLVERR, rresp=SLVERR, rdata=0; read 0x10 -> C_ID_VALUE, OKAY.
REQ-034 bready held low 10 cycles -> bvalid/bresp stable, awready/wready 0 throughout; rready low likewise holds rdata.
REQ-035 Assert reset with AW latched, W not yet sent -> all outputs 0 immediately; after release, W alone causes no write.
